// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package pipe_mem_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  // Run counter width; covers MAX_DM_RUN up to 15.
  localparam int RUN_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2,
    RESP    = 2'd3
  } arb_state_t;
endpackage

// File: rtl/pipe_mem_arb_grant.sv
// Priority decision between fetch and data, with a saturating run counter
// that forces a fetch grant after MAX_DM_RUN data grants made while fetch waits.
module pipe_mem_arb_grant
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int MAX_DM_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm
);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

  logic [RUN_W-1:0] run_cnt;
  logic             starve;

  // Data wins unless fetch has been starved for a full run.
  always_comb begin
    starve   = if_req && (run_cnt == RUN_MAX);
    grant_dm = arb_en && dm_req && !starve;
    grant_if = arb_en && if_req && !grant_dm;
  end

  // Count data grants that bypassed a waiting fetch; any other grant clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if (grant_if) begin
      run_cnt <= '0;
    end else if (grant_dm) begin
      if (!if_req)                run_cnt <= '0;
      else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pipe_mem_arbiter.sv
// Serialises instruction fetch and data accesses onto one req/ack memory.
// Each access: grant in IDLE, wait for mem_ack, one RESP cycle with a ready pulse.
module pipe_mem_arbiter
  import pipe_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_DM_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              memready,
  output logic              busy
);
  arb_state_t state;
  logic       arb_en;
  logic       grant_if;
  logic       grant_dm;

  assign arb_en   = (state == IDLE);
  assign busy     = (state != IDLE);
  assign memready = if_ready | dm_ready;

  pipe_mem_arb_grant #(.MAX_DM_RUN(MAX_DM_RUN)) u_grant (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm)
  );

  // Main FSM; all memory-side and requester-side outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= DM_WAIT;
          end else if (grant_if) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            state    <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
            state    <= RESP;
          end
        end
        DM_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            // Writes leave the last read value visible to the MEM stage.
            if (!mem_we) dm_rdata <= mem_rdata;
            dm_ready <= 1'b1;
            state    <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data-memory (MEM stage) port.
- Serialises the two requesters and drives the memory with a req/ack handshake.
- Returns a per-port ready pulse to both requesters. The OR of these pulses is the pipeline's memready, which the hazard unit uses to hold stages.
- Sits between Datapath_PipeLine's fetch/memory stages and the external memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_DM_RUN, 4, maximum consecutive data grants while if_req is pending before fetch is forced (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched instruction; valid with if_ready, held afterwards.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data; valid with dm_ready, held afterwards.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- memready  out  1  equals if_ready | dm_ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - All outputs become 0, including if_rdata and dm_rdata.
  - run counter clears.
  - Any in-flight memory transaction is abandoned: mem_req drops immediately, and a late mem_ack after reset release is ignored because the block is in IDLE.
- States:
  - IDLE: no transaction in flight.
  - IF_WAIT: fetch transaction outstanding on memory.
  - DM_WAIT: data transaction outstanding on memory.
  - RESP: one cycle in which the ready pulse is driven.
- IDLE arbitration (evaluated at the clock edge):
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data unless run counter == MAX_DM_RUN, in which case grant fetch.
  - Neither: stay in IDLE.
- On grant, the registered outputs mem_req/mem_we/mem_addr/mem_wdata load from the granted port, and the state moves to IF_WAIT or DM_WAIT. For a fetch grant, mem_we=0.
- Run counter:
  - Increments on each data grant made while if_req=1.
  - Clears on a fetch grant, or on any data grant made while if_req=0.
  - Saturates at MAX_DM_RUN.
- IF_WAIT / DM_WAIT:
  - mem_* outputs are held stable and requester inputs are not re-sampled.
  - On mem_ack=1: mem_req drops, read data is captured into if_rdata, or into dm_rdata only for data reads; dm_rdata is unchanged on writes. State moves to RESP.
- RESP:
  - Drives a one-cycle pulse on the matching ready (if_ready or dm_ready) and on memready.
  - Returns to IDLE next cycle, so there is exactly one ready pulse per grant.
  - Requesters update or drop req in the same cycle as ready, so IDLE samples a fresh request.
- Latency: request sampled at edge N gives mem_req high in cycle N+1. With a zero-wait memory (ack in N+1), ready is high in cycle N+2. Each access costs 3 cycles minimum: grant, ack, RESP.
- mem_ack while in IDLE or RESP: ignored, no state change.
- A request deasserted before its grant is simply never serviced. A request deasserted after its grant still completes on memory, and its ready pulse is still produced.
- if_ready and dm_ready are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, IF_WAIT=2'd1, DM_WAIT=2'd2, RESP=2'd3.
  - ADDR_W and DATA_W defaults.
- One natural sub-module: pipe_mem_arb_grant. It is the combinational priority decision plus the saturating run counter, and outputs grant_if/grant_dm from if_req, dm_req and the counter.

Test Plan:
- Reset mid DM_WAIT (mem_req=1), drop reset to 0 → mem_req, busy, dm_ready=0 immediately. After release, a stale mem_ack is ignored and state stays IDLE.
- if_req only, addr 0x40, memory acks 2 cycles after mem_req with 0x8C010004 → if_rdata=0x8C010004, one-cycle if_ready exactly 4 cycles after the sampling edge, memready matches it.
- Simultaneous if_req and dm_req (read 0x100, memory returns 0xDEADBEEF) → data serviced first (dm_rdata=0xDEADBEEF, dm_ready), then fetch serviced next, no overlapping ready pulses.
- dm_req write 0x200 / 0x12345678 → mem_we=1, mem_wdata=0x12345678 held until ack; dm_ready pulses; dm_rdata keeps its previous value.
- if_req held high while dm_req is re-asserted back-to-back, MAX_DM_RUN=4 → exactly 4 data grants, then a fetch grant, then the counter clears.
- Zero-wait memory (ack in the cycle mem_req rises) with back-to-back fetches → one ready every 3 cycles, mem_addr follows each new if_addr.
